// File: rtl/sort_pkg.sv
// sort_pkg: shared class codes, FSM state type and default servo timing for the sorter scheduler
package sort_pkg;
  localparam logic [1:0] CLS_PASS  = 2'b00;
  localparam logic [1:0] CLS_LEFT  = 2'b01;
  localparam logic [1:0] CLS_RIGHT = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} state_e;
  localparam int unsigned CLK_HZ       = 27_000_000;
  // 50 Hz servo PWM frame at 27 MHz
  localparam int unsigned PWM_PERIOD   = CLK_HZ / 50;
  localparam int unsigned TRAVEL_DEF   = 50_000_000;
  localparam int unsigned PULSE_DEF    = 4;
  // swing + return takes 30 PWM frames; lateness tolerance is 10 frames
  localparam int unsigned HOLD_DEF     = 30 * PWM_PERIOD;
  localparam int unsigned LATE_DEF     = 10 * PWM_PERIOD;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with flush
//   push_i/data_i write, pop_i/data_o read (data_o shows the head), flush_i empties,
//   full_o/empty_o/count_o report occupancy from registered state
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 33
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;
  always_comb begin
    do_push  = push_i && !full_o && !flush_i;
    do_pop   = pop_i && !empty_o && !flush_i;
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(do_pop);
    count_d  = flush_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/sort_scheduler.sv
// sort_scheduler: timestamps classified tiles and fires left/right servo triggers when they arrive
//   result_valid_i/result_class_i/result_ready_o: result handshake (00 pass, 10 right, 01/11 left)
//   flush_i: clear queued commands; left_o/right_o: registered trigger pulses
//   busy_o: pulse or hold in progress; pending_o: queued commands; miss_cnt_o: dropped commands
module sort_scheduler import sort_pkg::*; #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned TS_W          = 32,
  parameter int unsigned TRAVEL_CYCLES = TRAVEL_DEF,
  parameter int unsigned PULSE_CYCLES  = PULSE_DEF,
  parameter int unsigned HOLD_CYCLES   = HOLD_DEF,
  parameter int unsigned LATE_CYCLES   = LATE_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       result_valid_i,
  input  logic [1:0]                 result_class_i,
  output logic                       result_ready_o,
  input  logic                       flush_i,
  output logic                       left_o,
  output logic                       right_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic [15:0]                miss_cnt_o
);
  state_e          state_q, state_d;
  logic [TS_W-1:0] timer_q, timer_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [15:0]     miss_q, miss_d;
  logic            push, pop, full, empty;
  logic [TS_W:0]   head;
  logic [TS_W-1:0] diff;
  logic            head_due, head_late, last_pulse, last_hold;
  cmd_fifo #(.DEPTH(DEPTH), .W(TS_W + 1)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  ({result_class_i == CLS_RIGHT, timer_q + TS_W'(TRAVEL_CYCLES)}),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (pending_o)
  );
  // wrap-safe comparison: a non-negative difference (MSB clear) means the due time has passed
  always_comb begin
    timer_d        = timer_q + 1'b1;
    result_ready_o = !full;
    push           = result_valid_i && result_ready_o && result_class_i != CLS_PASS && !flush_i;
    diff           = timer_q - head[TS_W-1:0];
    head_due       = !empty && !diff[TS_W-1];
    head_late      = head_due && diff > TS_W'(LATE_CYCLES);
    last_pulse     = cnt_q == 32'(PULSE_CYCLES - 1);
    last_hold      = cnt_q == 32'(HOLD_CYCLES - 1);
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      miss_q  <= miss_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    miss_d  = miss_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE:
        if (!flush_i && head_due) begin
          pop = 1'b1;
          if (head_late) miss_d = miss_q == 16'hFFFF ? miss_q : miss_q + 16'd1;
          else begin
            state_d = ST_PULSE;
            cnt_d   = '0;
            dir_d   = head[TS_W];
          end
        end
      ST_PULSE: begin
        state_d = last_pulse ? ST_HOLD : ST_PULSE;
        cnt_d   = last_pulse ? '0 : cnt_q + 32'd1;
      end
      ST_HOLD: begin
        state_d = last_hold ? ST_IDLE : ST_HOLD;
        cnt_d   = last_hold ? '0 : cnt_q + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    left_o     = state_q == ST_PULSE && !dir_q;
    right_o    = state_q == ST_PULSE && dir_q;
    busy_o     = state_q != ST_IDLE;
    miss_cnt_o = miss_q;
  end
endmodule

// File: doc/sort_scheduler.md
Name: sort_scheduler

Overview:
- Sequences the servo sorter from the defect-detection result stream.
- Each classified tile result is timestamped on arrival and queued. When the tile reaches the servo, the block issues a left or right trigger pulse to the servo controller.
- Enforces the servo hold/return time between actuations.
- Drops commands that can no longer be served in time and counts them.

Parameters:
- DEPTH, 8, command FIFO entries (power of 2, ≥2)
- TS_W, 32, timestamp/timer width
- TRAVEL_CYCLES, 50_000_000, cycles from result acceptance to tile at servo (must be < 2^(TS_W-1))
- PULSE_CYCLES, 4, trigger high time (≥3, so the servo's 2-flop edge detector captures it)
- HOLD_CYCLES, 16_200_000, busy time after the pulse ends (servo swing + return)
- LATE_CYCLES, 5_400_000, maximum tolerated lateness before a command is dropped

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- result_valid_i  in  1  classification result valid
- result_class_i  in  2  00 pass, 01 reject-left, 10 reject-right, 11 reject-left
- result_ready_o  out  1  block can accept a result
- flush_i  in  1  synchronous clear of all queued commands
- left_o  out  1  servo left trigger
- right_o  out  1  servo right trigger
- busy_o  out  1  FSM not in IDLE
- pending_o  out  $clog2(DEPTH)+1  queued command count
- miss_cnt_o  out  16  dropped-command count, saturating at 0xFFFF

Behaviour:
- Reset: one clock, asynchronous, active-low. While rst_n_i is low, every output is 0 except result_ready_o, which is 1. Reset also clears the timer, FIFO and state. Reset mid-pulse drops left_o/right_o immediately.

Timer:
- Free-running TS_W counter, +1 per cycle, wraps modulo 2^TS_W.

Accept:
- A result is accepted on an edge where result_valid_i and result_ready_o are both high.
- result_ready_o = !full. It is combinational from the registered count, so a simultaneous pop does not raise ready.
- Class 00: accepted and discarded; nothing is enqueued.
- Other classes: push {dir, due}, where due = timer + TRAVEL_CYCLES (mod 2^TS_W) and dir is 0 for left, 1 for right.

Due and late tests (wrap-safe, d = timer − head.due mod 2^TS_W):
- Head is due when MSB(d) = 0.
- Head is late when it is due and d > LATE_CYCLES.

FSM states:
- IDLE: flush_i has priority. Otherwise, if the FIFO is non-empty and the head is due:
  - head late → pop, miss_cnt_o +1 (saturating), stay in IDLE (at most one drop per cycle);
  - head not late → pop, go to PULSE, latch dir.
- PULSE: left_o = (dir==0) or right_o = (dir==1), driven registered for exactly PULSE_CYCLES cycles, then go to HOLD. Both outputs are never high together.
- HOLD: HOLD_CYCLES cycles, then go to IDLE.

Latency:
- A non-late command accepted on edge T, with the FSM already in IDLE, raises its trigger starting at edge T+TRAVEL_CYCLES+1.

Concurrency and boundaries:
- Push and pop in the same cycle are allowed; count is unchanged.
- flush_i empties the FIFO only. A PULSE/HOLD in progress completes, miss_cnt_o is unchanged, and a push in the same cycle is discarded.
- Commands becoming due during PULSE/HOLD wait. They are evaluated for lateness on return to IDLE.

Decomposition:
- Shared package sort_pkg: class encoding constants (CLS_PASS, CLS_LEFT, CLS_RIGHT), FSM state enum, and the default timing constants, derived from the 27 MHz clock and the servo's 540_000-cycle PWM period.
- One sub-module: cmd_fifo, a synchronous FIFO of width TS_W+1 with push, pop, flush, full, empty and count outputs.

Test Plan:
All scenarios use DEPTH=4, TS_W=8, TRAVEL=100, PULSE=4, HOLD=50, LATE=20 unless stated.
1. Accept class 01 at edge 0 (timer=0) → left_o high edges 101–104, busy_o high 101–154, right_o stays 0, pending_o returns to 0 at 101.
2. Class 01 at edge 0, class 10 at edge 10 → left pulse 101–104. The second command is due at 110 and seen in IDLE at 155 with d=45 > 20, so it is dropped: miss_cnt_o = 1, right_o never rises.
3. Class 01 at edge 0, class 10 at edge 60 → right_o high edges 161–164, miss_cnt_o = 0.
4. Five back-to-back class 01 results starting at edge 0 → result_ready_o low after the 4th accept. The 5th is accepted on the first cycle after the edge-101 pop, and pending_o never exceeds 4.
5. Class 00 at edge 0 → accepted, pending_o stays 0, no trigger. flush_i pulsed at edge 50 with 3 queued commands → pending_o = 0 at 51, no trigger follows.
6. Class 10 accepted at timer=200 (wrap: due=44) → right_o rises exactly 101 edges later. Reset asserted during PULSE → right_o, busy_o and pending_o read 0 before the next clock edge.
